// File: rtl/spi_ram_if.sv
// Host command/response and SPI pin bundle for spi_ram_master.
// The master modport is the RAM controller side; slave is the host plus SPI device.
interface spi_ram_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       ss_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, MISO,
    output cmd_ready, rd_data, rd_valid, busy, ss_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, MISO,
    input  cmd_ready, rd_data, rd_valid, busy, ss_n, MOSI
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master for a byte RAM: 10-bit command frames, optional turnaround + 8-bit readback.
// Every output is a flop whose next value is derived from the next state.
module spi_ram_master #(
  parameter int unsigned TURN = 2,
  parameter int unsigned GAP  = 1
) (
  input  logic      clk,
  input  logic      rst,
  spi_ram_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_TURN, S_RECV, S_GAP} state_t;

  localparam logic [3:0] SEND_LAST = 4'd9;
  localparam logic [3:0] TURN_LAST = (TURN == 0) ? 4'd0 : 4'(TURN - 1);
  localparam logic [3:0] RECV_LAST = 4'd7;
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] tx_q, tx_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    is_rd_d    = is_rd_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = S_SEND;
          cnt_d   = '0;
          tx_d    = {bus.cmd_op, bus.cmd_data};
          is_rd_d = (bus.cmd_op == 2'b11);
          rx_d    = '0;
        end
      end
      S_SEND: begin
        if (cnt_q == SEND_LAST) begin
          cnt_d = '0;
          if (!is_rd_q)       state_d = S_GAP;
          else if (TURN == 0) state_d = S_RECV;
          else                state_d = S_TURN;
        end else begin
          cnt_d = cnt_q + 4'd1;
          tx_d  = {tx_q[8:0], 1'b0};
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RECV: begin
        // MISO is only looked at here, so junk on the line elsewhere never reaches rd_data
        rx_d = {rx_q[6:0], bus.MISO};
        if (cnt_q == RECV_LAST) begin
          cnt_d      = '0;
          rd_data_d  = {rx_q[6:0], bus.MISO};
          rd_valid_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs registered from the next state so they line up with it
    ss_n_d      = !(state_d == S_SEND || state_d == S_TURN || state_d == S_RECV);
    mosi_d      = (state_d == S_SEND) ? tx_d[9] : 1'b0;
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      is_rd_q     <= 1'b0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      is_rd_q     <= is_rd_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.ss_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule
